// File: rtl/mem32_bist.sv
// March-test BIST controller for the 64 x 32 mem32 array: W0 / R0W1 / R1 phases,
// reporting pass, first failing address and mismatch count.
//
// state | meaning
// IDLE  | array released, waiting for start
// W0    | ascending write of PATTERN
// R0W1  | ascending compare PATTERN, write ~PATTERN at the same address
// R1    | descending compare ~PATTERN
// DONE  | one-cycle completion pulse, pass latched on exit
module mem32_bist #(
  parameter logic [31:0] PATTERN = 32'hA5A5_5A5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] mem_q,
  output logic        mem_we,
  output logic [5:0]  mem_a,
  output logic [31:0] mem_d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  err_addr,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    R0W1 = 3'd2,
    R1   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [5:0] ADDR_TOP = 6'd63;
  localparam logic [5:0] ADDR_BOT = 6'd0;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  addr;
  logic        at_top;
  logic        at_bot;
  logic        accept;
  logic        cmp_en;
  logic [31:0] cmp_exp;
  logic        miss;
  logic        first_seen;

  assign at_top = (addr == ADDR_TOP);
  assign at_bot = (addr == ADDR_BOT);
  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = W0;
      W0:      if (at_top) state_nxt = R0W1;
      R0W1:    if (at_top) state_nxt = R1;
      R1:      if (at_bot) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_we = 1'b0;
    mem_a  = 6'd0;
    mem_d  = 32'd0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      W0: begin
        mem_we = 1'b1;
        mem_a  = addr;
        mem_d  = PATTERN;
        busy   = 1'b1;
      end
      R0W1: begin
        mem_we = 1'b1;
        mem_a  = addr;
        mem_d  = ~PATTERN;
        busy   = 1'b1;
      end
      R1: begin
        mem_a  = addr;
        busy   = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Phase terminal counts are explicit, so the counter never relies on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= 6'd0;
    end else begin
      case (state)
        IDLE:    addr <= 6'd0;
        W0:      addr <= at_top ? ADDR_BOT : addr + 6'd1;
        R0W1:    addr <= at_top ? ADDR_TOP : addr + 6'd1;
        R1:      addr <= at_bot ? ADDR_BOT : addr - 6'd1;
        default: addr <= 6'd0;
      endcase
    end
  end

  // R0W1 reads the old PATTERN before its own write lands at the edge.
  assign cmp_en  = (state == R0W1) || (state == R1);
  assign cmp_exp = (state == R1) ? ~PATTERN : PATTERN;
  assign miss    = cmp_en && (mem_q != cmp_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= 8'd0;
      err_addr   <= 6'd0;
      first_seen <= 1'b0;
      pass       <= 1'b0;
    end else if (accept) begin
      err_cnt    <= 8'd0;
      err_addr   <= 6'd0;
      first_seen <= 1'b0;
      pass       <= 1'b0;
    end else begin
      if (miss) begin
        err_cnt <= err_cnt + 8'd1;
        if (!first_seen) begin
          err_addr   <= addr;
          first_seen <= 1'b1;
        end
      end
      if (state == DONE) begin
        pass <= (err_cnt == 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_mem32_bist.sv
// Bench for mem32_bist: faulty-array model with stuck-at masks, march outcome
// predicted from the fault masks and compared with the controller's report.
module tb_mem32_bist;

  localparam logic [31:0] P = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] mem_q;
  logic        mem_we;
  logic [5:0]  mem_a;
  logic [31:0] mem_d;
  logic        busy;
  logic        done;
  logic        pass;
  logic [5:0]  err_addr;
  logic [7:0]  err_cnt;

  mem32_bist dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mem_q    (mem_q),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_addr (err_addr),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  logic [31:0] s0 [64];
  logic [31:0] s1 [64];
  logic [5:0]  wa_q [$];
  logic [31:0] wd_q [$];
  logic [5:0]  ra_q [$];

  assign mem_q = (mem[mem_a] & ~s0[mem_a]) | s1[mem_a];

  always @(posedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        mem[mem_a] <= mem_d;
        wa_q.push_back(mem_a);
        wd_q.push_back(mem_d);
      end else if (busy) begin
        ra_q.push_back(mem_a);
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int a, input logic [31:0] w);
    return (w & ~s0[a]) | s1[a];
  endfunction

  task automatic clear_faults();
    for (int a = 0; a < 64; a++) begin
      s0[a] = 32'd0;
      s1[a] = 32'd0;
    end
  endtask

  task automatic run_march(input string tag, input int restart_at, input int rst_at);
    int n;
    int exp_cnt;
    int exp_first;
    int busy_err;
    int seq_err;
    bit found;
    exp_cnt = 0;
    exp_first = 0;
    found = 0;
    for (int a = 0; a < 64; a++)
      if (rd(a, P) != P) begin
        if (!found) exp_first = a;
        found = 1;
        exp_cnt++;
      end
    for (int a = 63; a >= 0; a--)
      if (rd(a, ~P) != ~P) begin
        if (!found) exp_first = a;
        found = 1;
        exp_cnt++;
      end
    wa_q.delete();
    wd_q.delete();
    ra_q.delete();

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({tag, "/pass_clr"}, pass, 0);
    check({tag, "/cnt_clr"}, err_cnt, 0);
    busy_err = 0;
    while (n <= 400) begin
      if (done) break;
      if (!busy) busy_err++;
      if (n == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        check({tag, "/rst_we"}, mem_we, 0);
        check({tag, "/rst_busy"}, busy, 0);
        check({tag, "/rst_cnt"}, err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (n == restart_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    check({tag, "/done_cyc"}, n, 193);
    check({tag, "/busy"}, busy_err, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "/done_len"}, done, 0);
    check({tag, "/pass"}, pass, (exp_cnt == 0));
    check({tag, "/err_cnt"}, err_cnt, exp_cnt);
    check({tag, "/err_addr"}, err_addr, exp_first);
    @(negedge clk);
    check({tag, "/ign_done"}, busy, 0);

    seq_err = 0;
    if (wa_q.size() != 128) seq_err++;
    if (ra_q.size() != 64) seq_err++;
    for (int k = 0; k < wa_q.size() && k < 128; k++) begin
      if (wa_q[k] != 6'(k % 64)) seq_err++;
      if (wd_q[k] != ((k < 64) ? P : ~P)) seq_err++;
    end
    for (int k = 0; k < ra_q.size() && k < 64; k++)
      if (ra_q[k] != 6'(63 - k)) seq_err++;
    check({tag, "/seq"}, seq_err, 0);
  endtask

  initial begin
    int idle_err;
    int mem_err;
    int nf;
    int a;
    clear_faults();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst/busy", busy, 0);
    check("rst/we", mem_we, 0);
    check("rst/pass", pass, 0);
    check("rst/err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    idle_err = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_we || busy || done || pass || err_cnt != 0 || err_addr != 0 ||
          mem_a != 0 || mem_d != 0) idle_err++;
    end
    check("idle", idle_err, 0);

    run_march("good", -1, -1);
    mem_err = 0;
    for (int i = 0; i < 64; i++) if (mem[i] != ~P) mem_err++;
    check("good/final_mem", mem_err, 0);
    check("good/pass_abs", pass, 1);

    s0[10] = 32'h1;
    run_march("sa0b0", -1, -1);
    check("sa0b0/cnt_abs", err_cnt, 1);
    check("sa0b0/addr_abs", err_addr, 10);

    clear_faults();
    s0[10] = 32'hFFFF_FFFF;
    s0[40] = 32'hFFFF_FFFF;
    run_march("word0", -1, -1);
    check("word0/cnt_abs", err_cnt, 4);
    check("word0/addr_abs", err_addr, 10);

    clear_faults();
    run_march("restart", 50, -1);
    check("restart/cnt_abs", err_cnt, 0);

    run_march("rst_mid", -1, 100);
    check("rst_mid/pass", pass, 0);
    run_march("after_rst", -1, -1);
    check("after_rst/pass_abs", pass, 1);

    for (int r = 0; r < 4; r++) begin
      clear_faults();
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        a = $urandom_range(0, 63);
        s0[a] = $urandom;
        s1[a] = $urandom & ~s0[a];
      end
      run_march($sformatf("rand%0d", r), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
